// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: buffers received words, tracks occupancy,
// raises a threshold interrupt and a sticky overrun flag on dropped words.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  input  logic [AW:0]      thresh,
  output logic             irq,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_overrun;
  logic             r_irq;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_drop;
  logic [AW:0]      w_count_next;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_DEPTH);
  // A read never completes on an empty FIFO, even if a write lands this cycle.
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = rx_valid && en && (!w_full || w_rd_acc);
  assign w_drop   = rx_valid && en && w_full && !w_rd_acc;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_rd_valid <= w_rd_acc;
      r_irq      <= (w_count_next >= thresh) && (thresh != '0);
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + AW'(1);
      end
      // Set has priority over clear so a drop is never lost.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign irq      = r_irq;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: constant vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_uart_rx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic [AW:0]      thresh = '0;
  logic             irq;
  logic             overrun;
  logic             clr_ovr = 1'b0;

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .thresh(thresh), .irq(irq), .overrun(overrun),
    .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue plus the observable output registers.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_rd_data = '0;
  logic             m_rd_valid = 1'b0;
  logic             m_ovr = 1'b0;
  logic             m_irq = 1'b0;

  typedef struct {
    logic       rxv;
    logic [7:0] data;
    logic       rden;
    logic       en;
    int         exp_count;
    logic       exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovr      = 1'b0;
    m_irq      = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
  task automatic cycle(input logic rxv, input logic [7:0] d, input logic rde,
                       input logic e, input logic clr);
    bit rd, wr, drop, is_full;
    @(negedge clk);
    rx_valid = rxv; rx_data = d; rd_en = rde; en = e; clr_ovr = clr;
    is_full = (m_q.size() == DEPTH);
    rd   = rde && (m_q.size() != 0);
    wr   = rxv && e && (!is_full || rd);
    drop = rxv && e && is_full && !rd;
    m_rd_valid = rd;
    if (rd) m_rd_data = m_q.pop_front();
    if (wr) m_q.push_back(d);
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_irq = (m_q.size() >= int'(thresh)) && (thresh != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},    int'(count),    m_q.size());
    chk({tag, ".empty"},    int'(empty),    int'(m_q.size() == 0));
    chk({tag, ".full"},     int'(full),     int'(m_q.size() == DEPTH));
    chk({tag, ".rd_valid"}, int'(rd_valid), int'(m_rd_valid));
    chk({tag, ".rd_data"},  int'(rd_data),  int'(m_rd_data));
    chk({tag, ".overrun"},  int'(overrun),  int'(m_ovr));
    chk({tag, ".irq"},      int'(irq),      int'(m_irq));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rx_valid = 0; rd_en = 0; clr_ovr = 0;
    #2 arst_n = 1'b0;
    #1;
    chk({tag, ".count"},    int'(count),    0);
    chk({tag, ".empty"},    int'(empty),    1);
    chk({tag, ".full"},     int'(full),     0);
    chk({tag, ".rd_valid"}, int'(rd_valid), 0);
    chk({tag, ".overrun"},  int'(overrun),  0);
    chk({tag, ".irq"},      int'(irq),      0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset.count", int'(count), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full",  int'(full),  0);
    chk("reset.rd_valid", int'(rd_valid), 0);
    @(negedge clk);
    arst_n = 1'b1;
    en = 1'b1;

    // Basic ordering, empty-read corner, disabled writes.
    vecs = '{
      '{1, 8'h41, 0, 1, 1, 0, 8'h00},
      '{1, 8'h42, 0, 1, 2, 0, 8'h00},
      '{1, 8'h43, 0, 1, 3, 0, 8'h00},
      '{0, 8'h00, 1, 1, 2, 1, 8'h41},
      '{0, 8'h00, 1, 1, 1, 1, 8'h42},
      '{0, 8'h00, 1, 1, 0, 1, 8'h43},
      '{0, 8'h00, 0, 1, 0, 0, 8'h43},
      '{0, 8'h00, 1, 1, 0, 0, 8'h43},
      '{1, 8'h55, 1, 1, 1, 0, 8'h43},
      '{0, 8'h00, 1, 1, 0, 1, 8'h55},
      '{1, 8'h77, 0, 0, 0, 0, 8'h55},
      '{0, 8'h00, 1, 1, 0, 0, 8'h55}
    };
    foreach (vecs[i]) begin
      cycle(vecs[i].rxv, vecs[i].data, vecs[i].rden, vecs[i].en, 1'b0);
      chk($sformatf("vec%0d.count", i),    int'(count),    vecs[i].exp_count);
      chk($sformatf("vec%0d.empty", i),    int'(empty),    int'(vecs[i].exp_count == 0));
      chk($sformatf("vec%0d.rd_valid", i), int'(rd_valid), int'(vecs[i].exp_rv));
      chk($sformatf("vec%0d.rd_data", i),  int'(rd_data),  int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d.overrun", i),  int'(overrun),  0);
      $display("vec %0d: count=%0d rd_valid=%0d rd_data=%02h", i, count, rd_valid, rd_data);
    end

    // Fill, overflow, drain in order, clear overrun.
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h10 + i), 0, 1, 0);
    chk("fill.full", int'(full), 1);
    chk("fill.count", int'(count), 16);
    cycle(1, 8'hEE, 0, 1, 0);
    chk("ovf.overrun", int'(overrun), 1);
    chk("ovf.count", int'(count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 1, 0);
      chk($sformatf("drain%0d.rd_data", i), int'(rd_data), 8'h10 + i);
      check_model($sformatf("drain%0d", i));
    end
    $display("drain: count=%0d overrun=%0d", count, overrun);
    cycle(1, 8'h01, 0, 1, 1);
    chk("clr.overrun", int'(overrun), 0);
    cycle(0, 8'h00, 1, 1, 0);

    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h80 + i), 0, 1, 0);
    cycle(1, 8'hEF, 0, 1, 1);
    chk("setwins.overrun", int'(overrun), 1);
    cycle(0, 8'h00, 0, 1, 1);
    chk("clr2.overrun", int'(overrun), 0);

    // Full with simultaneous read and write.
    cycle(1, 8'hAA, 1, 1, 0);
    chk("fullrw.count", int'(count), 16);
    chk("fullrw.rd_data", int'(rd_data), 8'h80);
    chk("fullrw.overrun", int'(overrun), 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 1, 0);
      check_model($sformatf("fullrw_drain%0d", i));
    end
    chk("fullrw.last", int'(rd_data), 8'hAA);
    chk("fullrw.empty", int'(empty), 1);

    // Threshold interrupt.
    thresh = 5'd4;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'(i), 0, 1, 0);
      chk($sformatf("irq_w%0d", i), int'(irq), int'(i == 3));
    end
    cycle(0, 8'h00, 1, 1, 0);
    chk("irq_fall", int'(irq), 0);
    thresh = 5'd0;
    for (int i = 0; i < 3; i++) cycle(1, 8'(i), 0, 1, 0);
    chk("irq_zero", int'(irq), 0);
    check_model("irq_done");
    $display("irq: count=%0d irq=%0d", count, irq);

    // Randomized run with pointer wrap, checked against the queue model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) thresh = 5'($urandom_range(0, DEPTH));
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 15) == 0));
      check_model($sformatf("rnd%0d", i));
      $display("rnd %0d: count=%0d rd_valid=%0d rd_data=%02h ovr=%0d irq=%0d",
               i, count, rd_valid, rd_data, overrun, irq);
    end

    // Reset mid-operation with five words stored.
    thresh = 5'd2;
    pulse_reset("rst1");
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'hC0 + i), 0, 1, 0);
    cycle(0, 8'h00, 1, 1, 0);
    chk("pre_rst.count", int'(count), 5);
    chk("pre_rst.rd_valid", int'(rd_valid), 1);
    pulse_reset("rst2");
    cycle(0, 8'h00, 1, 1, 0);
    check_model("post_rst");
    cycle(1, 8'h5A, 0, 1, 0);
    cycle(0, 8'h00, 1, 1, 0);
    chk("post_rst.rd_data", int'(rd_data), 8'h5A);
    check_model("post_rst2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
